voter_auth_controller: RTL
==========================

Name: voter_auth_controller

Overview:
- Initiator side of the EVM voter-ID database lookup: captures a voter ID from the polling-booth keypad and drives the database read port (db_read, db_voter_id).
- Samples the returned valid_voter_id_status and grants exactly one ballot per authenticated voter via ballot_enable.
- Tracks which IDs have voted and times out idle ballots; sits between keypad/ID entry and the vote-recording unit.

Parameters:
- ID_W, 5, voter ID width; bitmap depth = 2**ID_W.
- DB_LATENCY, 1, clocks from db_read assertion to a valid db_valid_status (1..7).
- TIMEOUT, 200, clocks ballot_enable may stay high without vote_cast (>=2).
- CNT_W, 8, width of voted_count.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high; clears all state.
- mode  input  1  1 = voting session open; 0 = session closed (new requests ignored).
- id_valid  input  1  one-cycle strobe: id_in carries a voter ID.
- id_in  input  ID_W  voter ID from keypad.
- vote_cast  input  1  one-cycle strobe from vote-recording unit.
- db_valid_status  input  1  database response: 1 = ID registered.
- db_read  output  1  database read enable.
- db_voter_id  output  ID_W  ID presented to database.
- busy  output  1  high in any state except IDLE.
- ballot_enable  output  1  voting buttons enabled.
- auth_ok  output  1  one-cycle pulse on grant.
- auth_reject  output  1  one-cycle pulse on rejection.
- reject_code  output  2  0 none, 1 unregistered, 2 already voted, 3 ballot timeout; held until next request.
- voted_count  output  CNT_W  number of completed votes, saturating at all-ones.

Behaviour:
- Reset values: all outputs 0; FSM = IDLE; bitmap cleared; timers 0. Async assert, sync-safe deassert.
- All outputs registered.
- IDLE:
  - id_valid && mode -> capture id_in into db_voter_id, go to QUERY.
  - id_valid while busy, or while mode = 0, is dropped without response.
- QUERY:
  - db_read = 1 for exactly DB_LATENCY cycles; db_voter_id held stable.
  - db_valid_status is sampled on the cycle after the last db_read cycle -> CHECK.
- CHECK (1 cycle):
  - status = 0 -> auth_reject, reject_code = 1, go to IDLE.
  - Else if the ID's bitmap bit = 1 -> auth_reject, reject_code = 2, go to IDLE.
  - Else -> auth_ok, reject_code = 0, ballot_enable = 1, timer cleared, go to BALLOT.
- BALLOT:
  - vote_cast -> set the ID's bitmap bit, increment voted_count, ballot_enable = 0 next cycle, go to IDLE.
  - Timer reaches TIMEOUT-1 without vote_cast -> ballot_enable = 0, auth_reject, reject_code = 3, go to IDLE. The bit stays clear, so the voter may retry.
  - vote_cast on the same cycle as the timeout: vote_cast wins.
- vote_cast outside BALLOT is ignored.
- mode falling mid-transaction: the current transaction completes normally; only new requests are blocked.
- Request-to-grant latency: auth_ok is asserted DB_LATENCY+2 cycles after the id_valid edge.
- Reset mid-BALLOT: ballot_enable drops immediately (async); bitmap and count are cleared.

Optional Feature:
- Macro: DUP_VOTE_CHECK_EN.
- Defined: voted bitmap is implemented; reject_code 2 behaviour as above.
- Undefined: no bitmap registers; CHECK grants on status = 1 alone; reject_code 2 is never produced. voted_count still increments on vote_cast.

Test Plan:
- After reset, DB preloaded with 5'b11011, DB_LATENCY = 1: id_in = 11011 -> db_read high 1 cycle with db_voter_id = 11011, auth_ok 3 cycles after id_valid, ballot_enable = 1; vote_cast -> ballot_enable = 0, voted_count = 1.
- id_in = 00010 (unregistered) -> auth_reject, reject_code = 1, ballot_enable never rises, voted_count unchanged.
- Repeat 11011 after it has voted -> reject_code = 2 (DUP_VOTE_CHECK_EN defined); auth_ok instead with the macro undefined.
- Grant 11110 with TIMEOUT = 10, no vote_cast -> ballot_enable falls after 10 cycles, reject_code = 3; retry 11110 -> auth_ok.
- id_valid pulsed during QUERY, and vote_cast in IDLE -> both ignored; mode = 0 with id_valid -> no db_read.
- Assert reset during BALLOT -> ballot_enable = 0 without a clock edge; afterwards voted_count = 0 and a previously voted ID is granted again.

Source files
------------

// File: rtl/voter_auth_controller.sv
// Voter-ID authentication controller: keypad ID -> database lookup -> single ballot grant.
// Optional macro DUP_VOTE_CHECK_EN adds the voted-ID bitmap and duplicate-vote rejection.
module voter_auth_controller #(
    parameter int ID_W       = 5,
    parameter int DB_LATENCY = 1,
    parameter int TIMEOUT    = 200,
    parameter int CNT_W      = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             mode,
    input  logic             id_valid,
    input  logic [ID_W-1:0]  id_in,
    input  logic             vote_cast,
    input  logic             db_valid_status,
    output logic             db_read,
    output logic [ID_W-1:0]  db_voter_id,
    output logic             busy,
    output logic             ballot_enable,
    output logic             auth_ok,
    output logic             auth_reject,
    output logic [1:0]       reject_code,
    output logic [CNT_W-1:0] voted_count
);

    localparam int TMR_W = $clog2(TIMEOUT);
    localparam int LAT_W = 4;

    typedef enum logic [1:0] {IDLE, QUERY, CHECK, BALLOT} state_t;

    state_t            state_q, state_d;
    logic              db_read_q, db_read_d;
    logic [ID_W-1:0]   id_q, id_d;
    logic              busy_q, busy_d;
    logic              ballot_q, ballot_d;
    logic              ok_q, ok_d;
    logic              rej_q, rej_d;
    logic [1:0]        code_q, code_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [LAT_W-1:0]  lat_q, lat_d;
    logic [TMR_W-1:0]  timer_q, timer_d;
    logic              status_q, status_d;
    logic              already_voted;
`ifdef DUP_VOTE_CHECK_EN
    logic [(2**ID_W)-1:0] voted_q, voted_d;
`endif

`ifdef DUP_VOTE_CHECK_EN
    assign already_voted = voted_q[id_q];
`else
    assign already_voted = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        db_read_d = db_read_q;
        id_d      = id_q;
        busy_d    = busy_q;
        ballot_d  = ballot_q;
        ok_d      = 1'b0;
        rej_d     = 1'b0;
        code_d    = code_q;
        count_d   = count_q;
        lat_d     = lat_q;
        timer_d   = timer_q;
        status_d  = status_q;
`ifdef DUP_VOTE_CHECK_EN
        voted_d   = voted_q;
`endif
        case (state_q)
            IDLE: begin
                if (id_valid && mode) begin
                    id_d      = id_in;
                    state_d   = QUERY;
                    db_read_d = 1'b1;
                    lat_d     = '0;
                    busy_d    = 1'b1;
                    code_d    = 2'd0;
                end
            end
            QUERY: begin
                // db_read spans DB_LATENCY cycles; status is valid the cycle after
                lat_d = lat_q + LAT_W'(1);
                if (lat_q == LAT_W'(DB_LATENCY - 1))
                    db_read_d = 1'b0;
                if (lat_q == LAT_W'(DB_LATENCY)) begin
                    status_d = db_valid_status;
                    state_d  = CHECK;
                end
            end
            CHECK: begin
                if (!status_q) begin
                    rej_d   = 1'b1;
                    code_d  = 2'd1;
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end else if (already_voted) begin
                    rej_d   = 1'b1;
                    code_d  = 2'd2;
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end else begin
                    ok_d     = 1'b1;
                    code_d   = 2'd0;
                    ballot_d = 1'b1;
                    timer_d  = '0;
                    state_d  = BALLOT;
                end
            end
            BALLOT: begin
                // a vote arriving on the timeout cycle still counts
                if (vote_cast) begin
                    ballot_d = 1'b0;
                    state_d  = IDLE;
                    busy_d   = 1'b0;
                    if (count_q != '1)
                        count_d = count_q + CNT_W'(1);
`ifdef DUP_VOTE_CHECK_EN
                    voted_d[id_q] = 1'b1;
`endif
                end else if (timer_q == TMR_W'(TIMEOUT - 1)) begin
                    ballot_d = 1'b0;
                    rej_d    = 1'b1;
                    code_d   = 2'd3;
                    state_d  = IDLE;
                    busy_d   = 1'b0;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            db_read_q <= 1'b0;
            id_q      <= '0;
            busy_q    <= 1'b0;
            ballot_q  <= 1'b0;
            ok_q      <= 1'b0;
            rej_q     <= 1'b0;
            code_q    <= 2'd0;
            count_q   <= '0;
            lat_q     <= '0;
            timer_q   <= '0;
            status_q  <= 1'b0;
`ifdef DUP_VOTE_CHECK_EN
            voted_q   <= '0;
`endif
        end else begin
            state_q   <= state_d;
            db_read_q <= db_read_d;
            id_q      <= id_d;
            busy_q    <= busy_d;
            ballot_q  <= ballot_d;
            ok_q      <= ok_d;
            rej_q     <= rej_d;
            code_q    <= code_d;
            count_q   <= count_d;
            lat_q     <= lat_d;
            timer_q   <= timer_d;
            status_q  <= status_d;
`ifdef DUP_VOTE_CHECK_EN
            voted_q   <= voted_d;
`endif
        end
    end

    assign db_read       = db_read_q;
    assign db_voter_id   = id_q;
    assign busy          = busy_q;
    assign ballot_enable = ballot_q;
    assign auth_ok       = ok_q;
    assign auth_reject   = rej_q;
    assign reject_code   = code_q;
    assign voted_count   = count_q;

endmodule
